accel_spi3_responder: RTL and testbench

//  SPI 3-wire slave that behaves like the ADXL345 accelerometer, the far end of the accelerometer

---
 rtl/accel_spi3_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_accel_spi3_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi3_responder.sv
// ADXL345-style SPI 3-wire responder (CPOL=1, CPHA=1) with a 64x8 register file
// shared between the SPI bus and a local host port. SPI pins are oversampled on clk.
module accel_spi3_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hE5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_sdio_in,
  output logic       spi_sdio_out,
  output logic       spi_sdio_oe,
  input  logic       reg_wr_en,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wr_data,
  output logic [7:0] reg_rd_data,
  output logic       spi_wr_strobe,
  output logic [5:0] spi_wr_addr,
  output logic [7:0] spi_wr_data,
  output logic       spi_collision
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Bus handshake: there is no valid/ready pair here; the master owns all
  // timing through cs_n/sclk and the responder only reacts to detected edges.

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sdio_sync_q, sdio_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_in_q, shift_in_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [5:0]  addr_q, addr_d;
  logic        mb_q, mb_d;
  logic        oe_q, oe_d;
  logic        out_q, out_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        collision_q, collision_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  mem_q [64];
  logic [7:0]  mem_d [64];

  logic        cs_s, sclk_s, sdio_s;
  logic        cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [7:0]  byte_in;
  logic [5:0]  addr_inc;
  logic        spi_commit;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign byte_in   = {shift_in_q[6:0], sdio_s};
  assign addr_inc  = addr_q + 6'd1;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    sdio_sync_d = {sdio_sync_q[SYNC_STAGES-2:0], spi_sdio_in};
    cs_prev_d   = cs_s;
    sclk_prev_d = sclk_s;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    mb_d        = mb_q;
    oe_d        = oe_q;
    out_d       = out_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    spi_commit  = 1'b0;

    if (cs_rise) begin
      state_d   = S_IDLE;
      oe_d      = 1'b0;
      out_d     = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (cs_fall) begin
      // A fall outside IDLE is a glitch: abandon the frame and start a new one.
      state_d   = S_CMD;
      oe_d      = 1'b0;
      out_d     = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_CMD: begin
          if (sclk_rise) begin
            shift_in_d = byte_in;
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              addr_d    = byte_in[5:0];
              mb_d      = byte_in[6];
              if (byte_in[7]) begin
                state_d     = S_RDATA;
                shift_out_d = mem_q[byte_in[5:0]];
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (sclk_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d = S_DONE;
              oe_d    = 1'b0;
              out_d   = 1'b0;
            end else begin
              oe_d        = 1'b1;
              out_d       = shift_out_q[7];
              shift_out_d = {shift_out_q[6:0], 1'b0};
              bit_cnt_d   = bit_cnt_q + 4'd1;
              // Snapshot the next byte now so later host writes cannot tear it.
              if (bit_cnt_q == 4'd7 && mb_q) begin
                addr_d      = addr_inc;
                shift_out_d = mem_q[addr_inc];
                bit_cnt_d   = 4'd0;
              end
            end
          end
        end
        S_WDATA: begin
          if (sclk_rise) begin
            shift_in_d = byte_in;
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              spi_commit  = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = byte_in;
              bit_cnt_d   = 4'd0;
              if (mb_q) addr_d = addr_inc;
              else      state_d = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Host write is applied after the SPI commit so it wins on an address clash.
  always_comb begin
    mem_d = mem_q;
    if (spi_commit && addr_q != 6'd0) mem_d[addr_q] = byte_in;
    if (reg_wr_en) mem_d[reg_addr] = reg_wr_data;
    collision_d = spi_commit & reg_wr_en & (reg_addr == addr_q);
    rd_data_d   = mem_q[reg_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      sdio_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_in_q  <= 8'd0;
      shift_out_q <= 8'd0;
      addr_q      <= 6'd0;
      mb_q        <= 1'b0;
      oe_q        <= 1'b0;
      out_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 8'd0;
      collision_q <= 1'b0;
      rd_data_q   <= 8'd0;
      for (int i = 0; i < 64; i++) mem_q[i] <= (i == 0) ? DEVID : 8'h00;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      sdio_sync_q <= sdio_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      mb_q        <= mb_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      collision_q <= collision_d;
      rd_data_q   <= rd_data_d;
      mem_q       <= mem_d;
    end
  end

  assign spi_sdio_out  = out_q;
  assign spi_sdio_oe   = oe_q;
  assign reg_rd_data   = rd_data_q;
  assign spi_wr_strobe = wr_strobe_q;
  assign spi_wr_addr   = wr_addr_q;
  assign spi_wr_data   = wr_data_q;
  assign spi_collision = collision_q;

endmodule

// File: tb/tb_accel_spi3_responder.sv
// Bench for accel_spi3_responder: pin-level SPI master driver, a register-file
// reference model and a write-strobe scoreboard.
module tb_accel_spi3_responder;

  logic       clk;
  logic       reset_n;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_sdio_in;
  logic       spi_sdio_out;
  logic       spi_sdio_oe;
  logic       reg_wr_en;
  logic [5:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_data;
  logic       spi_wr_strobe;
  logic [5:0] spi_wr_addr;
  logic [7:0] spi_wr_data;
  logic       spi_collision;

  accel_spi3_responder #(.SYNC_STAGES(2), .DEVID(8'hE5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_cs_n     (spi_cs_n),
    .spi_sclk     (spi_sclk),
    .spi_sdio_in  (spi_sdio_in),
    .spi_sdio_out (spi_sdio_out),
    .spi_sdio_oe  (spi_sdio_oe),
    .reg_wr_en    (reg_wr_en),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_rd_data  (reg_rd_data),
    .spi_wr_strobe(spi_wr_strobe),
    .spi_wr_addr  (spi_wr_addr),
    .spi_wr_data  (spi_wr_data),
    .spi_collision(spi_collision)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [13:0] exp_q[$];
  logic [7:0]  model_mem[64];
  logic [7:0]  wbuf[8];
  int          half;
  int          coll_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
    model_mem[0] = 8'hE5;
  endtask

  // Every SPI commit must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (reset_n && spi_wr_strobe) begin
      check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [13:0] e;
        e = exp_q.pop_front();
        check("strobe_addr_data", {18'd0, spi_wr_addr, spi_wr_data}, {18'd0, e});
      end
    end
    if (reset_n && spi_collision) coll_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_wr_en = 1'b1; reg_addr = a; reg_wr_data = d;
    @(negedge clk);
    reg_wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic host_read_check(input logic [5:0] a);
    @(negedge clk);
    reg_addr = a;
    @(negedge clk);
    check("host_read", {24'd0, reg_rd_data}, {24'd0, model_mem[a]});
  endtask

  // One SCLK cycle: fall, master drives data, sample responder just before rise.
  task automatic spi_bit(input logic tx, output logic rx, output logic oe);
    @(negedge clk);
    spi_sclk = 1'b0; spi_sdio_in = tx;
    repeat (half) @(negedge clk);
    rx = spi_sdio_out; oe = spi_sdio_oe;
    spi_sclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_any, output logic oe_all);
    logic r, o;
    oe_any = 1'b0; oe_all = 1'b1; rx = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      spi_bit(tx[b], r, o);
      rx[b] = r; oe_any |= o; oe_all &= o;
    end
  endtask

  task automatic spi_start();
    half = $urandom_range(5, 9);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic spi_stop();
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1; spi_sclk = 1'b1;
    repeat (10) @(negedge clk);
    check("oe_after_frame", {31'd0, spi_sdio_oe}, 32'd0);
    check("strobes_drained", exp_q.size(), 32'd0);
  endtask

  // Whole transaction; read bytes come from the model, writes feed the model and scoreboard.
  task automatic spi_frame(input logic rd, input logic mb, input logic [5:0] a, input int n);
    logic [7:0] rx;
    logic       oe_any, oe_all;
    logic [5:0] ad;
    spi_start();
    spi_byte({rd, mb, a}, rx, oe_any, oe_all);
    check("cmd_oe_low", {31'd0, oe_any}, 32'd0);
    for (int i = 0; i < n; i++) begin
      ad = a + 6'(i);
      if (rd) begin
        spi_byte($urandom_range(0, 255), rx, oe_any, oe_all);
        check("spi_read_byte", {24'd0, rx}, {24'd0, model_mem[ad]});
        check("read_oe_high", {31'd0, oe_all}, 32'd1);
      end else begin
        exp_q.push_back({ad, wbuf[i]});
        if (ad != 6'd0) model_mem[ad] = wbuf[i];
        spi_byte(wbuf[i], rx, oe_any, oe_all);
        check("write_oe_low", {31'd0, oe_any}, 32'd0);
      end
    end
    spi_stop();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rx;
    logic       oe_any, oe_all, r, o;
    reset_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b1; spi_sdio_in = 1'b0;
    reg_wr_en = 1'b0; reg_addr = 6'd0; reg_wr_data = 8'd0; half = 6;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_oe", {31'd0, spi_sdio_oe}, 32'd0);
    check("rst_out", {31'd0, spi_sdio_out}, 32'd0);
    check("rst_strobe", {31'd0, spi_wr_strobe}, 32'd0);
    check("rst_wr_addr_data", {18'd0, spi_wr_addr, spi_wr_data}, 32'd0);
    check("rst_collision", {31'd0, spi_collision}, 32'd0);
    check("rst_rd_data", {24'd0, reg_rd_data}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    host_read_check(6'h00);

    // Read DEVID.
    spi_frame(1'b1, 1'b0, 6'h00, 1);

    // Single write, then host readback.
    wbuf[0] = 8'h08;
    spi_frame(1'b0, 1'b0, 6'h2D, 1);
    host_read_check(6'h2D);

    // Host preload, then multi-byte read of six registers.
    for (int i = 0; i < 6; i++) host_write(6'h32 + 6'(i), 8'(i + 1));
    spi_frame(1'b1, 1'b1, 6'h32, 6);

    // Multi-byte write wrapping 0x3F -> 0x00; 0x00 is read-only from SPI.
    wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
    spi_frame(1'b0, 1'b1, 6'h3F, 2);
    host_read_check(6'h3F);
    host_read_check(6'h00);

    // Aborted write after 5 data bits: nothing committed, next frame works.
    spi_start();
    spi_byte(8'h31, rx, oe_any, oe_all);
    for (int b = 0; b < 5; b++) spi_bit(1'b1, r, o);
    spi_stop();
    host_read_check(6'h31);
    wbuf[0] = 8'h5A;
    spi_frame(1'b0, 1'b0, 6'h31, 1);
    host_read_check(6'h31);

    // Host write and SPI commit to the same address in the same clk.
    check("collision_before", coll_cnt, 32'd0);
    spi_start();
    spi_byte(8'h20, rx, oe_any, oe_all);
    for (int b = 7; b >= 1; b--) spi_bit(b == 5 || b == 1, r, o);
    exp_q.push_back({6'h20, 8'h22});
    @(negedge clk);
    spi_sclk = 1'b0; spi_sdio_in = 1'b0;
    repeat (half) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (2) @(negedge clk);
    reg_wr_en = 1'b1; reg_addr = 6'h20; reg_wr_data = 8'h11;
    @(negedge clk);
    reg_wr_en = 1'b0;
    model_mem[6'h20] = 8'h11;
    repeat (half) @(negedge clk);
    spi_stop();
    check("collision_pulse", coll_cnt, 32'd1);
    host_read_check(6'h20);

    // Randomized frames and host writes against the model.
    for (int k = 0; k < 24; k++) begin
      logic       rd, mb;
      logic [5:0] a;
      int         n;
      if ($urandom_range(0, 2) == 0) host_write(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
      rd = 1'($urandom_range(0, 1));
      mb = 1'($urandom_range(0, 1));
      a  = (k % 4 == 3) ? 6'($urandom_range(61, 63)) : 6'($urandom_range(0, 63));
      n  = mb ? $urandom_range(2, 3) : 1;
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
      spi_frame(rd, mb, a, n);
      if (!rd) host_read_check(a);
    end
    check("collision_total", coll_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
